// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave receiver.
package i2c_pkg;

    localparam int unsigned I2C_ADDR_W = 7;
    localparam int unsigned I2C_BYTE_W = 8;
    localparam logic [I2C_ADDR_W-1:0] I2C_GCALL_ADDR = 7'h00;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ACK_ADDR = 3'd2,
        DATA     = 3'd3,
        ACK_DATA = 3'd4,
        IGNORE   = 3'd5
    } i2c_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers with registered edge, START and STOP pulses.
// Total detection latency from a pin change to a pulse is SYNC_STAGES+1 clk.
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_bit,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sr;
    logic [SYNC_STAGES-1:0] sda_sr;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;
    logic                   sda_s;

    assign scl_s = scl_sr[SYNC_STAGES-1];
    assign sda_s = sda_sr[SYNC_STAGES-1];

    // Idle bus level is high, so reset to 1 to avoid spurious edges.
    always_ff @(posedge clk) begin
        if (!rst) begin
            scl_sr    <= '1;
            sda_sr    <= '1;
            scl_d     <= 1'b1;
            sda_d     <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            sda_bit   <= 1'b1;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_sr    <= {scl_sr[SYNC_STAGES-2:0], scl_in};
            sda_sr    <= {sda_sr[SYNC_STAGES-2:0], sda_in};
            scl_d     <= scl_s;
            sda_d     <= sda_s;
            scl_rise  <= scl_s & ~scl_d;
            scl_fall  <= ~scl_s & scl_d;
            sda_bit   <= sda_s;
            start_det <= scl_s & scl_d & sda_d & ~sda_s;
            stop_det  <= scl_s & scl_d & ~sda_d & sda_s;
        end
    end

endmodule

// File: rtl/i2c_slave_rx.sv
// Write-only I2C slave receiver with valid/ready byte output.
// Define I2C_SLV_GCALL_EN to also accept the general-call address 7'h00.
module i2c_slave_rx
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
    parameter int unsigned           SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic [I2C_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_first,
    output logic                  busy,
    output logic                  stop_det,
    output logic                  overflow
);

    logic scl_rise;
    logic scl_fall;
    logic sda_bit;
    logic start_det;
    logic bus_stop;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .sda_bit  (sda_bit),
        .start_det(start_det),
        .stop_det (bus_stop)
    );

    i2c_state_t            state;
    logic [3:0]            bit_cnt;
    logic [I2C_BYTE_W-1:0] shreg;
    logic                  first_pending;
    logic                  addr_hit;
    logic                  consume;
    logic                  byte_done;

    assign consume   = rx_valid & rx_ready;
    assign byte_done = scl_fall && (bit_cnt == 4'd8);

    always_comb begin
        addr_hit = (shreg[I2C_BYTE_W-1:1] == SLAVE_ADDR);
`ifdef I2C_SLV_GCALL_EN
        if (shreg[I2C_BYTE_W-1:1] == I2C_GCALL_ADDR) addr_hit = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shreg         <= '0;
            first_pending <= 1'b0;
            sda_oe        <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_first      <= 1'b0;
            busy          <= 1'b0;
            stop_det      <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            stop_det <= 1'b0;
            overflow <= 1'b0;
            if (consume) rx_valid <= 1'b0;

            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
            end else if (bus_stop) begin
                state    <= IDLE;
                busy     <= 1'b0;
                stop_det <= 1'b1;
                sda_oe   <= 1'b0;
            end else begin
                if (scl_rise && (state == ADDR || state == DATA)) begin
                    shreg   <= {shreg[I2C_BYTE_W-2:0], sda_bit};
                    bit_cnt <= bit_cnt + 4'd1;
                end
                case (state)
                    IDLE: ;
                    ADDR: begin
                        if (byte_done) begin
                            if (addr_hit && !shreg[0]) begin
                                state         <= ACK_ADDR;
                                sda_oe        <= 1'b1;
                                busy          <= 1'b1;
                                first_pending <= 1'b1;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    ACK_ADDR, ACK_DATA: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        // A byte consumed on this same clk frees the slot for the new one.
                        if (byte_done) begin
                            if (!rx_valid || rx_ready) begin
                                rx_data       <= shreg;
                                rx_valid      <= 1'b1;
                                rx_first      <= first_pending;
                                first_pending <= 1'b0;
                                sda_oe        <= 1'b1;
                                state         <= ACK_DATA;
                            end else begin
                                overflow <= 1'b1;
                                state    <= IGNORE;
                            end
                        end
                    end
                    IGNORE: sda_oe <= 1'b0;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Randomized self-checking bench for i2c_slave_rx against a transaction-level model.
module tb_i2c_slave_rx;

    localparam int Q = 10;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       rx_ready = 1'b0;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_first;
    logic       busy;
    logic       stop_det;
    logic       overflow;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave_rx #(
        .SLAVE_ADDR (7'h50),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .scl_in  (scl_m),
        .sda_in  (sda_bus),
        .sda_oe  (sda_oe),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .rx_first(rx_first),
        .busy    (busy),
        .stop_det(stop_det),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         oe_cnt = 0;
    int         stop_cnt = 0;
    int         ovf_cnt = 0;
    int         exp_stops = 0;
    int         exp_ovf = 0;
    bit         model_valid = 1'b0;
    bit         model_busy = 1'b0;
    logic [8:0] exp_q[$];
    logic [7:0] tx_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Consumer side: every accepted byte must be the next one the model predicted.
    always @(negedge clk) begin
        if (rst) begin
            if (sda_oe) oe_cnt++;
            if (stop_det) stop_cnt++;
            if (overflow) ovf_cnt++;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) check("rx_unexpected", 32'({rx_first, rx_data}), 32'h1ff);
                else check("rx_byte", 32'({rx_first, rx_data}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic wait_q(input int n = 1);
        repeat (n * Q) @(negedge clk);
    endtask

    task automatic set_ready(input bit r);
        @(posedge clk);
        #1 rx_ready = r;
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
        exp_stops++;
        model_busy = 1'b0;
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    wait_q();
        scl_m = 1'b1; wait_q(2);
        scl_m = 1'b0; wait_q();
    endtask

    task automatic read_ack(output bit ack);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        ack = ~sda_bus;
        wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_ack(ack);
    endtask

    function automatic bit addr_ok(input logic [6:0] a, input bit rw);
        bit hit;
        hit = (a == 7'h50);
`ifdef I2C_SLV_GCALL_EN
        if (a == 7'h00) hit = 1'b1;
`endif
        return hit && !rw;
    endfunction

    // START, address, then every byte in tx_q; no STOP.
    task automatic do_xfer(input logic [6:0] a, input bit rw, input bit ready);
        bit ack;
        bit exp_ack;
        bit dropped;
        int oe0;
        set_ready(ready);
        if (ready) model_valid = 1'b0;
        bus_start();
        oe0 = oe_cnt;
        exp_ack = addr_ok(a, rw);
        send_byte({a, rw}, ack);
        check("addr_ack", 32'(ack), 32'(exp_ack));
        if (exp_ack) model_busy = 1'b1;
        check("busy", 32'(busy), 32'(model_busy));
        dropped = !exp_ack;
        for (int i = 0; i < tx_q.size(); i++) begin
            if (dropped) begin
                send_byte(tx_q[i], ack);
                check("data_nack_ign", 32'(ack), 32'd0);
            end else if (ready || !model_valid) begin
                exp_q.push_back({(i == 0) ? 1'b1 : 1'b0, tx_q[i]});
                if (!ready) model_valid = 1'b1;
                send_byte(tx_q[i], ack);
                check("data_ack", 32'(ack), 32'd1);
            end else begin
                exp_ovf++;
                dropped = 1'b1;
                send_byte(tx_q[i], ack);
                check("data_nack_full", 32'(ack), 32'd0);
            end
        end
        if (!exp_ack) check("oe_never", 32'(oe_cnt - oe0), 32'd0);
    endtask

    initial begin
        bit ack;
        int oe0;
        int ovf0;

        repeat (5) @(negedge clk);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_first", 32'(rx_first), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stop_det", 32'(stop_det), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b1;
        wait_q(2);

        tx_q = '{8'hA5, 8'h3C};
        do_xfer(7'h50, 1'b0, 1'b1);
        bus_stop();
        check("busy_after_stop", 32'(busy), 32'd0);

        tx_q = '{8'h12};
        do_xfer(7'h51, 1'b0, 1'b1);
        bus_stop();

        do_xfer(7'h50, 1'b1, 1'b1);
        bus_stop();

        ovf0 = ovf_cnt;
        tx_q = '{8'h11, 8'h22};
        do_xfer(7'h50, 1'b0, 1'b0);
        check("ovf_pulse", 32'(ovf_cnt - ovf0), 32'd1);
        check("held_data", 32'(rx_data), 32'h11);
        check("held_valid", 32'(rx_valid), 32'd1);
        bus_stop();

        tx_q = '{8'h01};
        do_xfer(7'h50, 1'b0, 1'b1);
        tx_q = '{8'h02};
        do_xfer(7'h50, 1'b0, 1'b1);
        bus_stop();

        // Reset while the slave is ACKing the second byte.
        set_ready(1'b1);
        model_valid = 1'b0;
        bus_start();
        send_byte({7'h50, 1'b0}, ack);
        check("rt_addr_ack", 32'(ack), 32'd1);
        exp_q.push_back({1'b1, 8'hC3});
        send_byte(8'hC3, ack);
        check("rt_b1_ack", 32'(ack), 32'd1);
        exp_q.push_back({1'b0, 8'h5A});
        for (int i = 7; i >= 0; i--) write_bit(8'h5A >> i);
        check("rt_pre_oe", 32'(sda_oe), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("rt_oe_released", 32'(sda_oe), 32'd0);
        check("rt_busy", 32'(busy), 32'd0);
        check("rt_valid", 32'(rx_valid), 32'd0);
        rst = 1'b1;
        model_busy = 1'b0;
        sda_m = 1'b1;
        scl_m = 1'b1; wait_q(2);
        scl_m = 1'b0; wait_q();
        oe0 = oe_cnt;
        send_byte(8'h99, ack);
        check("rt_post_ack", 32'(ack), 32'd0);
        check("rt_post_oe", 32'(oe_cnt - oe0), 32'd0);
        bus_stop();
        check("rt_post_valid", 32'(rx_valid), 32'd0);

        tx_q = '{8'h77};
        do_xfer(7'h00, 1'b0, 1'b1);
        bus_stop();

        for (int t = 0; t < 16; t++) begin
            logic [6:0] a;
            case ($urandom_range(0, 3))
                0, 1:    a = 7'h50;
                2:       a = 7'h00;
                default: a = 7'($urandom_range(0, 127));
            endcase
            tx_q.delete();
            repeat ($urandom_range(1, 3)) tx_q.push_back(8'($urandom_range(0, 255)));
            do_xfer(a, $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0);
            bus_stop();
        end

        set_ready(1'b1);
        wait_q(2);
        check("drain", 32'(exp_q.size()), 32'd0);
        check("stop_count", 32'(stop_cnt), 32'(exp_stops));
        check("ovf_count", 32'(ovf_cnt), 32'(exp_ovf));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
